icache_direct_mapped: RTL and testbench

//  Direct-mapped, one-word-per-block instruction cache between the pipelined datapath's fetch stage
//  and the memory/cache controller. Serves imemREN/imemaddr with a combinational ihit/imemload.
//  On a miss it issues a single-word read (iREN/iaddr) and fills the entry once iwait drops.
//  The datapath stalls (pcEn=0) while ihit=0, so no pipeline changes are needed.

---
 rtl/icache_direct_mapped_if.sv | 30 +++
 rtl/icache_direct_mapped.sv | 123 ++++++++++++
 tb/tb_icache_direct_mapped.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_direct_mapped_if.sv
// Fetch-side and memory-side signal bundle for the direct-mapped instruction cache.
//   flush            : invalidate every cache entry this cycle
//   imemREN/imemaddr : datapath fetch request and byte address
//   ihit/imemload    : same-cycle hit indication and instruction word (0 on miss)
//   iREN/iaddr       : memory-side single-word read request and word address
//   iwait/iload      : memory busy flag and read data (valid when iREN=1, iwait=0)
// Modports: slave = cache side, master = datapath/memory side driving the cache.
interface icache_direct_mapped_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              flush;
  logic              imemREN;
  logic [ADDR_W-1:0] imemaddr;
  logic              ihit;
  logic [ADDR_W-1:0] imemload;
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [ADDR_W-1:0] iload;

  modport slave (
    input  flush, imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output flush, imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_direct_mapped.sv
// Direct-mapped, one-word-per-block instruction cache between fetch and memory.
// Hits are answered combinationally; a miss launches one single-word read and
// fills the entry when iwait drops, after which the request hits.
//   CLK  : clock, rising edge
//   nRST : asynchronous active-low reset (clears FSM and all valid bits)
//   bus  : icache_direct_mapped_if.slave (fetch request/response, memory read)
module icache_direct_mapped #(
  parameter int unsigned SETS   = 16,
  parameter int unsigned ADDR_W = 32
) (
  input logic                   CLK,
  input logic                   nRST,
  icache_direct_mapped_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  miss_addr_q, miss_addr_d;
  logic               flush_pend_q, flush_pend_d;
  logic [SETS-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [TAG_W-1:0]   tag_d  [SETS];
  logic [ADDR_W-1:0]  data_q [SETS];
  logic [ADDR_W-1:0]  data_d [SETS];

  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               hit;
  logic               unused_addr_lsb;

  // Address split: byte offset dropped, then index, then tag
  assign req_idx  = bus.imemaddr[IDX_W+1:2];
  assign req_tag  = bus.imemaddr[ADDR_W-1:IDX_W+2];
  assign fill_idx = miss_addr_q[IDX_W+1:2];
  assign fill_tag = miss_addr_q[ADDR_W-1:IDX_W+2];
  assign unused_addr_lsb = ^bus.imemaddr[1:0];

  // Lookup is only trusted in IDLE; a same-cycle flush wins over a hit
  assign hit = (state_q == IDLE) && bus.imemREN && valid_q[req_idx] &&
               (tag_q[req_idx] == req_tag) && !bus.flush;

  assign bus.ihit     = hit;
  assign bus.imemload = hit ? data_q[req_idx] : '0;
  assign bus.iREN     = (state_q == FILL);
  assign bus.iaddr    = miss_addr_q;

  // Next-state, miss launch and fill write
  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;

    case (state_q)
      IDLE: begin
        if (bus.imemREN && !hit && !bus.flush) begin
          miss_addr_d  = {bus.imemaddr[ADDR_W-1:2], 2'b00};
          flush_pend_d = 1'b0;
          state_d      = FILL;
        end
      end
      FILL: begin
        // A flush seen anywhere in this FILL poisons the fill it belongs to
        if (bus.flush) begin
          flush_pend_d = 1'b1;
        end
        if (!bus.iwait) begin
          state_d = IDLE;
          if (!bus.flush && !flush_pend_q) begin
            valid_d[fill_idx] = 1'b1;
            tag_d[fill_idx]   = fill_tag;
            data_d[fill_idx]  = bus.iload;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush) begin
      valid_d = '0;
    end
  end

  // Control and valid state
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      miss_addr_q  <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
    end
  end

  // Tag/data arrays are qualified by valid, so they carry no reset
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  a_iaddr_aligned: assert property (@(posedge CLK) disable iff (!nRST)
    bus.iaddr[1:0] == 2'b00);
  a_iren_fill: assert property (@(posedge CLK) disable iff (!nRST)
    bus.iREN == (state_q == FILL));
  a_hit_no_iren: assert property (@(posedge CLK) disable iff (!nRST)
    bus.ihit |-> !bus.iREN);

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed self-checking bench for icache_direct_mapped. Inputs change on the
// falling edge; outputs are sampled 1 time unit later, well away from the rising edge.
module tb_icache_direct_mapped;

  logic CLK;
  logic nRST;
  int   checks;
  int   failures;

  icache_direct_mapped_if #(.ADDR_W(32)) bus ();

  icache_direct_mapped #(
    .SETS  (16),
    .ADDR_W(32)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full miss: detect cycle, `waits` busy FILL cycles, one completing cycle, then a hit
  task automatic do_miss(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input int waits);
    @(negedge CLK);
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    bus.iwait    = 1'b1;
    #1;
    check({tag, "_miss_ihit"}, 32'(bus.ihit), 32'd0);
    check({tag, "_miss_load"}, bus.imemload, 32'd0);
    for (int i = 0; i < waits; i++) begin
      @(negedge CLK);
      #1;
      check({tag, "_busy_iren"}, 32'(bus.iREN), 32'd1);
      check({tag, "_busy_iaddr"}, bus.iaddr, {addr[31:2], 2'b00});
    end
    @(negedge CLK);
    bus.iwait = 1'b0;
    bus.iload = data;
    #1;
    check({tag, "_done_iren"}, 32'(bus.iREN), 32'd1);
    check({tag, "_done_iaddr"}, bus.iaddr, {addr[31:2], 2'b00});
    @(negedge CLK);
    bus.iwait = 1'b1;
    #1;
    check({tag, "_after_ihit"}, 32'(bus.ihit), 32'd1);
    check({tag, "_after_load"}, bus.imemload, data);
    check({tag, "_after_iren"}, 32'(bus.iREN), 32'd0);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    nRST         = 1'b0;
    bus.flush    = 1'b0;
    bus.imemREN  = 1'b0;
    bus.imemaddr = '0;
    bus.iwait    = 1'b1;
    bus.iload    = '0;

    // Reset held for 2 cycles
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("rst_ihit", 32'(bus.ihit), 32'd0);
    check("rst_iren", 32'(bus.iREN), 32'd0);
    check("rst_load", bus.imemload, 32'd0);
    check("rst_iaddr", bus.iaddr, 32'd0);
    nRST = 1'b1;

    // Address 0 misses after reset
    do_miss("cold0", 32'h0000_0000, 32'h1111_1111, 0);

    // Cold miss on 0x40 with three busy cycles (evicts 0x0, same index)
    do_miss("cold40", 32'h0000_0040, 32'h2001_000A, 3);

    // Re-read hits in the same cycle; byte offset is ignored
    @(negedge CLK);
    bus.imemaddr = 32'h0000_0043;
    #1;
    check("rehit_ihit", 32'(bus.ihit), 32'd1);
    check("rehit_load", bus.imemload, 32'h2001_000A);
    check("rehit_iren", 32'(bus.iREN), 32'd0);

    // imemREN low: no hit, zero data
    @(negedge CLK);
    bus.imemREN = 1'b0;
    #1;
    check("noren_ihit", 32'(bus.ihit), 32'd0);
    check("noren_load", bus.imemload, 32'd0);
    @(negedge CLK);
    #1;
    check("noren_iren", 32'(bus.iREN), 32'd0);

    // Conflict: 0x80 shares index 0 and evicts 0x40
    do_miss("conf80", 32'h0000_0080, 32'hDEAD_BEEF, 1);
    do_miss("evict40", 32'h0000_0040, 32'h2001_000A, 0);

    // Address change mid-FILL: iaddr stays 0x100
    @(negedge CLK);
    bus.imemaddr = 32'h0000_0100;
    bus.iwait    = 1'b1;
    #1;
    check("chg_miss", 32'(bus.ihit), 32'd0);
    @(negedge CLK);
    bus.imemaddr = 32'h0000_0200;
    #1;
    check("chg_iaddr1", bus.iaddr, 32'h0000_0100);
    check("chg_nohit", 32'(bus.ihit), 32'd0);
    @(negedge CLK);
    bus.iwait = 1'b0;
    bus.iload = 32'hCAFE_F00D;
    #1;
    check("chg_iaddr2", bus.iaddr, 32'h0000_0100);
    @(negedge CLK);
    bus.iwait    = 1'b1;
    bus.imemaddr = 32'h0000_0100;
    #1;
    check("chg_hit100", 32'(bus.ihit), 32'd1);
    check("chg_load100", bus.imemload, 32'hCAFE_F00D);
    @(negedge CLK);
    bus.imemaddr = 32'h0000_0200;
    #1;
    check("chg_miss200", 32'(bus.ihit), 32'd0);
    // Miss on 0x200 launches; drop imemREN mid-FILL, fill must still complete
    @(negedge CLK);
    bus.imemREN = 1'b0;
    bus.iwait   = 1'b0;
    bus.iload   = 32'h0000_0200;
    #1;
    check("drop_iren", 32'(bus.iREN), 32'd1);
    check("drop_iaddr", bus.iaddr, 32'h0000_0200);
    @(negedge CLK);
    bus.iwait   = 1'b1;
    bus.imemREN = 1'b1;
    #1;
    check("drop_hit200", 32'(bus.ihit), 32'd1);
    check("drop_load200", bus.imemload, 32'h0000_0200);

    // A different index does not disturb index 0
    do_miss("idx1", 32'h0000_0044, 32'h4444_4444, 2);
    @(negedge CLK);
    bus.imemaddr = 32'h0000_0200;
    #1;
    check("idx0_keep", bus.imemload, 32'h0000_0200);

    // Flush in IDLE suppresses a hit and the miss launch
    @(negedge CLK);
    bus.imemaddr = 32'h0000_0044;
    bus.flush    = 1'b1;
    #1;
    check("flidle_ihit", 32'(bus.ihit), 32'd0);
    @(negedge CLK);
    bus.flush   = 1'b0;
    bus.imemREN = 1'b0;
    #1;
    check("flidle_iren", 32'(bus.iREN), 32'd0);
    do_miss("flidle44", 32'h0000_0044, 32'h4545_4545, 0);

    // Flush early in FILL: bus read completes, entry stays invalid
    @(negedge CLK);
    bus.imemaddr = 32'h0000_004C;
    #1;
    check("flfill_miss", 32'(bus.ihit), 32'd0);
    @(negedge CLK);
    bus.flush = 1'b1;
    #1;
    check("flfill_iren1", 32'(bus.iREN), 32'd1);
    @(negedge CLK);
    bus.flush = 1'b0;
    bus.iwait = 1'b0;
    bus.iload = 32'h5555_AAAA;
    #1;
    check("flfill_iren2", 32'(bus.iREN), 32'd1);
    check("flfill_iaddr", bus.iaddr, 32'h0000_004C);
    @(negedge CLK);
    bus.iwait = 1'b1;
    #1;
    check("flfill_inval", 32'(bus.ihit), 32'd0);
    check("flfill_load0", bus.imemload, 32'd0);
    @(negedge CLK);
    bus.iwait = 1'b0;
    bus.iload = 32'h4C4C_4C4C;
    #1;
    check("flfill_refill", 32'(bus.iREN), 32'd1);
    @(negedge CLK);
    bus.iwait = 1'b1;
    #1;
    check("flfill_rehit", 32'(bus.ihit), 32'd1);
    check("flfill_reload", bus.imemload, 32'h4C4C_4C4C);

    // Flush on the completing edge of FILL also discards the write
    @(negedge CLK);
    bus.imemaddr = 32'h0000_0050;
    #1;
    check("fledge_miss", 32'(bus.ihit), 32'd0);
    @(negedge CLK);
    bus.iwait = 1'b0;
    bus.flush = 1'b1;
    bus.iload = 32'h5050_5050;
    #1;
    check("fledge_iren", 32'(bus.iREN), 32'd1);
    @(negedge CLK);
    bus.iwait   = 1'b1;
    bus.flush   = 1'b0;
    #1;
    check("fledge_inval", 32'(bus.ihit), 32'd0);
    @(negedge CLK);
    bus.imemREN = 1'b0;
    bus.iwait   = 1'b0;
    #1;
    check("fledge_relaunch", 32'(bus.iREN), 32'd1);
    @(negedge CLK);
    bus.iwait = 1'b1;
    #1;
    check("fledge_idle", 32'(bus.iREN), 32'd0);

    // Reset mid-FILL returns to IDLE at once and clears valid
    do_miss("prerst", 32'h0000_0058, 32'h5858_5858, 0);
    @(negedge CLK);
    bus.imemaddr = 32'h0000_0054;
    @(negedge CLK);
    #1;
    check("rstfill_iren", 32'(bus.iREN), 32'd1);
    nRST = 1'b0;
    #1;
    check("rstfill_iren0", 32'(bus.iREN), 32'd0);
    check("rstfill_iaddr0", bus.iaddr, 32'd0);
    @(negedge CLK);
    nRST         = 1'b1;
    bus.imemaddr = 32'h0000_0058;
    #1;
    check("rstfill_inval", 32'(bus.ihit), 32'd0);
    @(negedge CLK);
    bus.imemREN = 1'b0;
    bus.iwait   = 1'b0;
    #1;
    check("rstfill_launch", 32'(bus.iREN), 32'd1);
    @(negedge CLK);
    bus.iwait = 1'b1;
    #1;
    check("rstfill_idle", 32'(bus.iREN), 32'd0);

    @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
